// File: rtl/unslicer.sv
// unslicer: expands each packed 32-bit soft-bit word into 1, 2, 4, 8 or 16 I/Q sample words.
// Define UNSLICER_MIDFILL_EN to set the bit just below the restored bits (mid-rise fill).
module unslicer (
  input  logic        clk,
  input  logic        srst,
  input  logic        dmaReset,
  input  logic [31:0] config_payload_slice,
  input  logic [31:0] config_payload_length,
  input  logic        config_valid,
  output logic        unslicer_busy,
  output logic        cfg_error,
  input  logic [31:0] t0_data,
  input  logic        t0_last,
  input  logic        t0_valid,
  output logic        t0_ready,
  output logic [31:0] i0_data,
  output logic        i0_last,
  output logic        i0_valid,
  input  logic        i0_ready
);

  logic [3:0]  r_slice;
  logic [31:0] r_length;
  logic [31:0] r_txnCnt;
  logic        r_busy;
  logic        r_drain;
  logic        r_cfgError;

  logic [31:0] r_holdData;
  logic        r_holdLast;
  logic        r_holdValid;
  logic [3:0]  r_idx;

  logic [31:0] r_outData;
  logic        r_outLast;
  logic        r_outValid;

  logic        w_flush;
  logic        w_sliceLegal;
  logic [3:0]  w_lastIdx;
  logic        w_idxAtEnd;
  logic        w_outLoad;
  logic        w_holdDone;
  logic        w_inFire;
  logic        w_payloadEnd;
  logic [31:0] w_sub;

  assign w_flush      = srst | dmaReset;
  assign w_sliceLegal = (config_payload_slice == 32'd0) || (config_payload_slice == 32'd1) ||
                        (config_payload_slice == 32'd2) || (config_payload_slice == 32'd4) ||
                        (config_payload_slice == 32'd8);

  always_comb begin
    w_lastIdx = 4'd0;
    case (r_slice)
      4'd1:    w_lastIdx = 4'd15;
      4'd2:    w_lastIdx = 4'd7;
      4'd4:    w_lastIdx = 4'd3;
      4'd8:    w_lastIdx = 4'd1;
      default: w_lastIdx = 4'd0;
    endcase
  end

  // >= rather than == so a mode change under an occupied hold still frees it
  assign w_idxAtEnd = r_idx >= w_lastIdx;
  assign w_outLoad  = ~r_outValid | i0_ready;
  assign w_holdDone = r_holdValid & w_outLoad & w_idxAtEnd;
  assign t0_ready   = ~w_flush & (~r_holdValid | (w_idxAtEnd & w_outLoad));
  assign w_inFire   = t0_valid & t0_ready;

  assign w_payloadEnd = (r_length != 32'd0) ? (r_txnCnt == (r_length - 32'd1)) : t0_last;

  // Sub-word j takes the I group at bit 2kj and the Q group right above it
  always_comb begin
    w_sub = '0;
    case (r_slice)
      4'd1: begin
        w_sub[15] = r_holdData[{r_idx, 1'b0}];
        w_sub[31] = r_holdData[{r_idx, 1'b1}];
      end
      4'd2: begin
        w_sub[15:14] = r_holdData[{r_idx[2:0], 2'b00} +: 2];
        w_sub[31:30] = r_holdData[{r_idx[2:0], 2'b10} +: 2];
      end
      4'd4: begin
        w_sub[15:12] = r_holdData[{r_idx[1:0], 3'b000} +: 4];
        w_sub[31:28] = r_holdData[{r_idx[1:0], 3'b100} +: 4];
      end
      4'd8: begin
        w_sub[15:8]  = r_holdData[{r_idx[0], 4'b0000} +: 8];
        w_sub[31:24] = r_holdData[{r_idx[0], 4'b1000} +: 8];
      end
      default: w_sub = r_holdData;
    endcase
`ifdef UNSLICER_MIDFILL_EN
    case (r_slice)
      4'd1: begin
        w_sub[14] = 1'b1;
        w_sub[30] = 1'b1;
      end
      4'd2: begin
        w_sub[13] = 1'b1;
        w_sub[29] = 1'b1;
      end
      4'd4: begin
        w_sub[11] = 1'b1;
        w_sub[27] = 1'b1;
      end
      4'd8: begin
        w_sub[7]  = 1'b1;
        w_sub[23] = 1'b1;
      end
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_slice    <= 4'd0;
      r_length   <= 32'd0;
      r_txnCnt   <= 32'd0;
      r_busy     <= 1'b0;
      r_drain    <= 1'b0;
      r_cfgError <= 1'b0;
    end else if (config_valid && !r_busy) begin
      r_slice    <= w_sliceLegal ? config_payload_slice[3:0] : 4'd0;
      r_length   <= config_payload_length;
      r_txnCnt   <= 32'd0;
      r_busy     <= 1'b1;
      r_drain    <= 1'b0;
      r_cfgError <= r_cfgError | ~w_sliceLegal;
    end else if (r_busy) begin
      if (w_inFire && !r_drain) begin
        if (w_payloadEnd) begin
          r_txnCnt <= 32'd0;
          r_drain  <= 1'b1;
        end else begin
          r_txnCnt <= r_txnCnt + 32'd1;
        end
      end
      if (r_drain && !r_holdValid && !r_outValid) begin
        r_busy  <= 1'b0;
        r_drain <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_holdData  <= 32'd0;
      r_holdLast  <= 1'b0;
      r_holdValid <= 1'b0;
      r_idx       <= 4'd0;
    end else begin
      if (r_holdValid && w_outLoad)
        r_idx <= w_idxAtEnd ? 4'd0 : r_idx + 4'd1;
      if (w_inFire) begin
        r_holdData  <= t0_data;
        r_holdLast  <= t0_last;
        r_holdValid <= 1'b1;
      end else if (w_holdDone) begin
        r_holdValid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_outData  <= 32'd0;
      r_outLast  <= 1'b0;
      r_outValid <= 1'b0;
    end else if (w_outLoad) begin
      if (r_holdValid) begin
        r_outData  <= w_sub;
        r_outLast  <= r_holdLast & w_idxAtEnd;
        r_outValid <= 1'b1;
      end else begin
        r_outLast  <= 1'b0;
        r_outValid <= 1'b0;
      end
    end
  end

  assign i0_data       = r_outData;
  assign i0_last       = r_outLast;
  assign i0_valid      = r_outValid;
  assign unslicer_busy = r_busy;
  assign cfg_error     = r_cfgError;

endmodule

// File: tb/tb_unslicer.sv
// tb_unslicer: randomized checks of unslicer against a shift-based expansion model.
module tb_unslicer;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        dmaReset = 1'b0;
  logic [31:0] config_payload_slice = 32'd0;
  logic [31:0] config_payload_length = 32'd0;
  logic        config_valid = 1'b0;
  logic        unslicer_busy;
  logic        cfg_error;
  logic [31:0] t0_data = 32'd0;
  logic        t0_last = 1'b0;
  logic        t0_valid = 1'b0;
  logic        t0_ready;
  logic [31:0] i0_data;
  logic        i0_last;
  logic        i0_valid;
  logic        i0_ready = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stallErr = 0;
  int rdyMode = 0;
  int inEdge = 0;

  logic [31:0] gotData[$];
  logic        gotLast[$];
  int          gotCyc[$];
  logic [31:0] expData[$];
  logic        expLast[$];

  unslicer dut (
    .clk(clk), .srst(srst), .dmaReset(dmaReset),
    .config_payload_slice(config_payload_slice),
    .config_payload_length(config_payload_length),
    .config_valid(config_valid),
    .unslicer_busy(unslicer_busy), .cfg_error(cfg_error),
    .t0_data(t0_data), .t0_last(t0_last), .t0_valid(t0_valid), .t0_ready(t0_ready),
    .i0_data(i0_data), .i0_last(i0_last), .i0_valid(i0_valid), .i0_ready(i0_ready)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdyMode)
      0:       i0_ready = 1'b1;
      1:       i0_ready = 1'b0;
      default: i0_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: records every accepted sub-word and counts stall instability
  initial begin
    logic        prevStall;
    logic [31:0] prevData;
    logic        prevLast;
    prevStall = 1'b0;
    prevData  = 32'd0;
    prevLast  = 1'b0;
    forever begin
      @(negedge clk);
      if (srst || dmaReset) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall && (i0_valid !== 1'b1 || i0_data !== prevData || i0_last !== prevLast))
          stallErr++;
        if (i0_valid && i0_ready) begin
          gotData.push_back(i0_data);
          gotLast.push_back(i0_last);
          gotCyc.push_back(cyc);
        end
        prevStall = i0_valid && !i0_ready;
        prevData  = i0_data;
        prevLast  = i0_last;
      end
    end
  end

  task automatic clear_q();
    gotData.delete();
    gotLast.delete();
    gotCyc.delete();
    expData.delete();
    expLast.delete();
  endtask

  // Reference: sub-word j carries I bits from 2kj and Q bits from 2kj+k, left-justified
  task automatic model_word(input logic [31:0] w, input int k, input logic l);
    int          n;
    logic [31:0] mask;
    logic [31:0] iv;
    logic [31:0] qv;
    logic [15:0] ih;
    logic [15:0] qh;
    n = (k == 0) ? 1 : 16 / k;
    for (int j = 0; j < n; j++) begin
      if (k == 0) begin
        expData.push_back(w);
      end else begin
        mask = (32'd1 << k) - 32'd1;
        iv = (w >> (2 * k * j)) & mask;
        qv = (w >> (2 * k * j + k)) & mask;
        ih = 16'(iv << (16 - k));
        qh = 16'(qv << (16 - k));
`ifdef UNSLICER_MIDFILL_EN
        ih = ih | 16'(32'd1 << (15 - k));
        qh = qh | 16'(32'd1 << (15 - k));
`endif
        expData.push_back({qh, ih});
      end
      expLast.push_back(l && (j == n - 1));
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [31:0] s, input logic [31:0] len);
    config_payload_slice  = s;
    config_payload_length = len;
    config_valid = 1'b1;
    sync();
    config_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    t0_data  = d;
    t0_last  = l;
    t0_valid = 1'b1;
    while (!ok && n < 500) begin
      @(negedge clk);
      if (t0_ready === 1'b1) begin
        ok = 1'b1;
        inEdge = cyc + 1;
      end else begin
        n++;
      end
    end
    sync();
    t0_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout data=%h t0_ready stuck low, required 1", d);
    end
  endtask

  task automatic wait_outputs(input int n);
    int b;
    b = 0;
    while (gotData.size() < n && b < 2000) begin
      @(posedge clk);
      b++;
    end
    #1;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    @(negedge clk);
    while (unslicer_busy !== 1'b0 && b < 2000) begin
      @(negedge clk);
      b++;
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b0;
    @(negedge clk);
    total++; if (i0_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", i0_valid); end
    total++; if (i0_data !== 32'd0) begin bad++; $display("FAIL rst_data got=%h exp=0", i0_data); end
    total++; if (i0_last !== 1'b0) begin bad++; $display("FAIL rst_last got=%b exp=0", i0_last); end
    total++; if (unslicer_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", unslicer_busy); end
    total++; if (cfg_error !== 1'b0) begin bad++; $display("FAIL rst_cfgerr got=%b exp=0", cfg_error); end
    total++; if (t0_ready !== 1'b1) begin bad++; $display("FAIL rst_t0ready got=%b exp=1", t0_ready); end
    sync();
  endtask

  task automatic test_passthrough();
    int firstIn;
    clear_q();
    rdyMode = 0;
    configure(32'd0, 32'd3);
    @(negedge clk);
    total++; if (unslicer_busy !== 1'b1) begin bad++; $display("FAIL pt_busy_set got=%b exp=1", unslicer_busy); end
    sync();
    model_word(32'h11112222, 0, 1'b0);
    model_word(32'h33334444, 0, 1'b0);
    model_word(32'h55556666, 0, 1'b1);
    send(32'h11112222, 1'b0);
    firstIn = inEdge;
    send(32'h33334444, 1'b0);
    send(32'h55556666, 1'b1);
    wait_outputs(3);
    total++; if (gotData.size() != expData.size()) begin bad++; $display("FAIL pt_count got=%0d exp=%0d", gotData.size(), expData.size()); end
    for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
      total++;
      if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
        bad++; $display("FAIL pt_word[%0d] got=%h/%b exp=%h/%b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
      end
    end
    total++;
    if (gotCyc.size() < 3 || gotCyc[0] - firstIn != 1 || gotCyc[2] - gotCyc[0] != 2) begin
      bad++; $display("FAIL pt_timing first_out_edge=%0d in_edge=%0d (out must follow 1 edge later, 1/cycle)",
                      (gotCyc.size() > 0) ? gotCyc[0] : -1, firstIn);
    end
    wait_idle();
    total++; if (unslicer_busy !== 1'b0) begin bad++; $display("FAIL pt_busy_clear got=%b exp=0", unslicer_busy); end
    sync();
  endtask

  task automatic test_slice1();
    clear_q();
    rdyMode = 0;
    configure(32'd1, 32'd0);
    model_word(32'h00000003, 1, 1'b1);
    send(32'h00000003, 1'b1);
    wait_outputs(16);
    total++; if (gotData.size() != expData.size()) begin bad++; $display("FAIL s1_count got=%0d exp=%0d", gotData.size(), expData.size()); end
    for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
      total++;
      if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
        bad++; $display("FAIL s1_word[%0d] got=%h/%b exp=%h/%b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
      end
    end
    wait_idle();
    total++; if (unslicer_busy !== 1'b0) begin bad++; $display("FAIL s1_busy_clear got=%b exp=0", unslicer_busy); end
    sync();
  endtask

  task automatic test_back_to_back();
    clear_q();
    rdyMode = 0;
    configure(32'd8, 32'd2);
    model_word(32'hA1B2C3D4, 8, 1'b0);
    model_word(32'h0F0E0D0C, 8, 1'b1);
    send(32'hA1B2C3D4, 1'b0);
    send(32'h0F0E0D0C, 1'b1);
    wait_outputs(4);
    total++; if (gotData.size() != expData.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", gotData.size(), expData.size()); end
    for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
      total++;
      if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
        bad++; $display("FAIL b2b_word[%0d] got=%h/%b exp=%h/%b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
      end
    end
    for (int i = 1; i < gotCyc.size(); i++) begin
      total++;
      if (gotCyc[i] - gotCyc[i-1] != 1) begin
        bad++; $display("FAIL b2b_gap[%0d] got=%0d exp=1", i, gotCyc[i] - gotCyc[i-1]);
      end
    end
    wait_idle();
    sync();
  endtask

  task automatic test_backpressure();
    logic [31:0] w[7];
    clear_q();
    stallErr = 0;
    for (int i = 0; i < 7; i++) begin
      w[i] = $urandom;
      model_word(w[i], 4, i == 6);
    end
    configure(32'd4, 32'd0);
    rdyMode = 1;
    sync();
    sync();
    send(w[0], 1'b0);
    t0_data  = w[1];
    t0_last  = 1'b0;
    t0_valid = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (t0_ready !== 1'b0) begin bad++; $display("FAIL bp_t0ready_stalled got=%b exp=0", t0_ready); end
    total++; if (i0_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_stalled got=%b exp=1", i0_valid); end
    total++; if (i0_data !== expData[0]) begin bad++; $display("FAIL bp_data_stalled got=%h exp=%h", i0_data, expData[0]); end
    total++; if (gotData.size() != 0) begin bad++; $display("FAIL bp_no_output_stalled got=%0d exp=0", gotData.size()); end
    sync();
    rdyMode = 2;
    for (int i = 1; i < 7; i++) send(w[i], i == 6);
    wait_outputs(28);
    total++; if (gotData.size() != expData.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", gotData.size(), expData.size()); end
    for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
      total++;
      if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
        bad++; $display("FAIL bp_word[%0d] got=%h/%b exp=%h/%b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
      end
    end
    total++; if (stallErr != 0) begin bad++; $display("FAIL bp_stall_stable got=%0d changes exp=0", stallErr); end
    rdyMode = 0;
    wait_idle();
    total++; if (unslicer_busy !== 1'b0) begin bad++; $display("FAIL bp_busy_clear got=%b exp=0", unslicer_busy); end
    sync();
  endtask

  task automatic test_cfg_error();
    logic [31:0] a;
    logic [31:0] b;
    clear_q();
    rdyMode = 0;
    configure(32'd5, 32'd1);
    @(negedge clk);
    total++; if (cfg_error !== 1'b1) begin bad++; $display("FAIL cfg_err_set got=%b exp=1", cfg_error); end
    sync();
    model_word(32'hDEADBEEF, 0, 1'b1);
    send(32'hDEADBEEF, 1'b1);
    wait_outputs(1);
    total++;
    if (gotData.size() != 1 || gotData[0] !== 32'hDEADBEEF || gotLast[0] !== 1'b1) begin
      bad++; $display("FAIL cfg_illegal_pt got=%h count=%0d exp=%h", (gotData.size() > 0) ? gotData[0] : 32'hx, gotData.size(), expData[0]);
    end
    wait_idle();
    sync();
    clear_q();
    a = $urandom;
    b = $urandom;
    model_word(a, 8, 1'b0);
    model_word(b, 8, 1'b1);
    configure(32'd8, 32'd2);
    send(a, 1'b0);
    configure(32'd1, 32'd0);
    send(b, 1'b1);
    wait_outputs(4);
    total++; if (gotData.size() != expData.size()) begin bad++; $display("FAIL ign_count got=%0d exp=%0d", gotData.size(), expData.size()); end
    for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
      total++;
      if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
        bad++; $display("FAIL ign_word[%0d] got=%h/%b exp=%h/%b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
      end
    end
    wait_idle();
    total++; if (cfg_error !== 1'b1) begin bad++; $display("FAIL cfg_err_sticky got=%b exp=1", cfg_error); end
    sync();
  endtask

  task automatic test_dma_reset();
    logic [31:0] w;
    int          cnt;
    int          b;
    clear_q();
    rdyMode = 0;
    w = $urandom;
    model_word(w, 1, 1'b1);
    configure(32'd1, 32'd0);
    send(w, 1'b1);
    cnt = 0;
    b = 0;
    while (cnt < 3 && b < 500) begin
      @(negedge clk);
      if (i0_valid && i0_ready) cnt++;
      b++;
    end
    sync();
    dmaReset = 1'b1;
    sync();
    dmaReset = 1'b0;
    @(negedge clk);
    total++; if (i0_valid !== 1'b0) begin bad++; $display("FAIL dma_valid got=%b exp=0", i0_valid); end
    total++; if (unslicer_busy !== 1'b0) begin bad++; $display("FAIL dma_busy got=%b exp=0", unslicer_busy); end
    repeat (20) @(negedge clk);
    total++; if (gotData.size() != 3) begin bad++; $display("FAIL dma_no_partial got=%0d exp=3", gotData.size()); end
    for (int i = 0; i < 3 && i < gotData.size(); i++) begin
      total++;
      if (gotData[i] !== expData[i]) begin
        bad++; $display("FAIL dma_pre_word[%0d] got=%h exp=%h", i, gotData[i], expData[i]);
      end
    end
    sync();
    clear_q();
    w = $urandom;
    model_word(w, 2, 1'b1);
    configure(32'd2, 32'd1);
    send(w, 1'b1);
    wait_outputs(8);
    total++; if (gotData.size() != expData.size()) begin bad++; $display("FAIL dma_new_count got=%0d exp=%0d", gotData.size(), expData.size()); end
    for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
      total++;
      if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
        bad++; $display("FAIL dma_new_word[%0d] got=%h/%b exp=%h/%b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
      end
    end
    wait_idle();
    total++; if (unslicer_busy !== 1'b0) begin bad++; $display("FAIL dma_new_busy got=%b exp=0", unslicer_busy); end
    sync();
  endtask

  task automatic test_random();
    int          modes[5];
    int          k;
    int          nw;
    int          useLen;
    logic [31:0] w;
    modes = '{0, 1, 2, 4, 8};
    for (int p = 0; p < 6; p++) begin
      clear_q();
      k = modes[$urandom_range(0, 4)];
      nw = $urandom_range(1, 4);
      useLen = $urandom_range(0, 1);
      rdyMode = 0;
      configure(k, (useLen != 0) ? nw : 0);
      rdyMode = 2;
      for (int i = 0; i < nw; i++) begin
        w = $urandom;
        model_word(w, k, i == nw - 1);
        send(w, i == nw - 1);
      end
      wait_outputs(expData.size());
      total++; if (gotData.size() != expData.size()) begin bad++; $display("FAIL rnd%0d_count k=%0d got=%0d exp=%0d", p, k, gotData.size(), expData.size()); end
      for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
        total++;
        if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
          bad++; $display("FAIL rnd%0d_word[%0d] k=%0d got=%h/%b exp=%h/%b", p, i, k, gotData[i], gotLast[i], expData[i], expLast[i]);
        end
      end
      rdyMode = 0;
      wait_idle();
      total++; if (unslicer_busy !== 1'b0) begin bad++; $display("FAIL rnd%0d_busy got=%b exp=0", p, unslicer_busy); end
      sync();
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_slice1();
    test_back_to_back();
    test_backpressure();
    test_cfg_error();
    test_dma_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
